// File: rtl/dma_pkg.sv
// Shared types and defaults for the N-dimensional DMA address generator.
// Holds the FSM encoding, default widths and the packed-field offset helper.
package dma_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dma_state_e;

  localparam int DMA_AW   = 14;
  localparam int DMA_NDIM = 3;
  localparam int DMA_SW   = 8;
  localparam int DMA_STW  = 8;

  // LSB position of field k in a packed per-dimension vector of w-bit fields.
  function automatic int field_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/dma_dim_cnt.sv
// One dimension of the walker: index, origin, latched size/step and the wrap/advance update.
// DMA_DIMN_SIGNED_STEP_EN selects sign-extension of the step field; otherwise it is zero-extended.
module dma_dim_cnt
  import dma_pkg::*;
#(
  parameter int AW  = DMA_AW,
  parameter int SW  = DMA_SW,
  parameter int STW = DMA_STW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [AW-1:0]  base,
  input  logic [SW-1:0]  size_in,
  input  logic [STW-1:0] step_in,
  input  logic           inc,
  input  logic           clr,
  input  logic [AW-1:0]  origin_ld,
  output logic           is_final,
  output logic           nxt_final,
  output logic [AW-1:0]  origin_inc
);

  logic [SW-1:0]  idx_q, idx_d;
  logic [SW-1:0]  size_q, size_d;
  logic [STW-1:0] step_q, step_d;
  logic [AW-1:0]  origin_q, origin_d;
  logic [AW-1:0]  step_ext;

`ifdef DMA_DIMN_SIGNED_STEP_EN
  assign step_ext = AW'($signed(step_q));
`else
  assign step_ext = AW'(step_q);
`endif

  assign origin_inc = origin_q + step_ext;
  assign is_final   = (idx_q == size_q);
  assign nxt_final  = (idx_d == size_d);

  always_comb begin
    idx_d    = idx_q;
    size_d   = size_q;
    step_d   = step_q;
    origin_d = origin_q;
    if (load) begin
      idx_d    = '0;
      size_d   = size_in;
      step_d   = step_in;
      origin_d = base;
    end else if (inc) begin
      idx_d    = idx_q + SW'(1);
      origin_d = origin_inc;
    end else if (clr) begin
      // Wrapping: restart this dimension at the origin of the dimension that advanced.
      idx_d    = '0;
      origin_d = origin_ld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      size_q   <= '0;
      step_q   <= '0;
      origin_q <= '0;
    end else begin
      idx_q    <= idx_d;
      size_q   <= size_d;
      step_q   <= step_d;
      origin_q <= origin_d;
    end
  end

endmodule

// File: rtl/dma_dimn.sv
// N-dimensional DMA address generator: start handshake at T gives first beat at T+1, one beat/cycle, outputs held while s_ready is low.
// Optional DMA_DIMN_SIGNED_STEP_EN treats step fields as signed; one idle cycle separates descriptors.
module dma_dimn
  import dma_pkg::*;
#(
  parameter int AW   = DMA_AW,
  parameter int NDIM = DMA_NDIM,
  parameter int SW   = DMA_SW,
  parameter int STW  = DMA_STW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     base,
  input  logic [NDIM*SW-1:0]  size,
  input  logic [NDIM*STW-1:0] step,
  input  logic              start_valid,
  output logic              start_ready,
  output logic [AW-1:0]     s_addr,
  output logic              s_first,
  output logic              s_last,
  output logic [NDIM-1:0]   s_dim_last,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              busy
);

  dma_state_e state_q, state_d;
  logic [AW-1:0]   s_addr_q, s_addr_d;
  logic            s_first_q, s_first_d;
  logic            s_last_q, s_last_d;
  logic [NDIM-1:0] s_dim_last_q, s_dim_last_d;
  logic            s_valid_q, s_valid_d;

  logic            load, fire, all_final;
  logic [NDIM-1:0] is_final, nxt_final, lower_final, inc, clr, nxt_dim_last;
  logic [AW-1:0]   origin_inc [NDIM];
  logic [AW-1:0]   origin_ld;

  assign load = (state_q == ST_IDLE) && start_valid;
  assign fire = s_valid_q && s_ready;

  genvar g;
  generate
    for (g = 0; g < NDIM; g++) begin : g_dim
      assign inc[g] = fire && lower_final[g] && !is_final[g];
      assign clr[g] = fire && !all_final && lower_final[g] && is_final[g];

      dma_dim_cnt #(
        .AW  (AW),
        .SW  (SW),
        .STW (STW)
      ) u_dim (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .base       (base),
        .size_in    (size[field_lo(g, SW) +: SW]),
        .step_in    (step[field_lo(g, STW) +: STW]),
        .inc        (inc[g]),
        .clr        (clr[g]),
        .origin_ld  (origin_ld),
        .is_final   (is_final[g]),
        .nxt_final  (nxt_final[g]),
        .origin_inc (origin_inc[g])
      );
    end
  endgenerate

  // The lowest non-final dimension advances; its stepped origin reseeds everything below it.
  always_comb begin
    logic acc;
    acc         = 1'b1;
    lower_final = '0;
    for (int k = 0; k < NDIM; k++) begin
      lower_final[k] = acc;
      acc            = acc & is_final[k];
    end
    all_final = acc;
    origin_ld = origin_inc[NDIM-1];
    for (int k = NDIM - 1; k >= 0; k--) begin
      if (!is_final[k]) origin_ld = origin_inc[k];
    end
  end

  always_comb begin
    logic nacc;
    nacc         = 1'b1;
    nxt_dim_last = '0;
    for (int k = 0; k < NDIM; k++) begin
      nacc            = nacc & nxt_final[k];
      nxt_dim_last[k] = nacc;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_addr_d     = s_addr_q;
    s_first_d    = s_first_q;
    s_last_d     = s_last_q;
    s_dim_last_d = s_dim_last_q;
    s_valid_d    = s_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d      = ST_RUN;
          s_valid_d    = 1'b1;
          s_first_d    = 1'b1;
          s_addr_d     = base;
          s_dim_last_d = nxt_dim_last;
          s_last_d     = nxt_dim_last[NDIM-1];
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (s_last_q) begin
            state_d      = ST_IDLE;
            s_valid_d    = 1'b0;
            s_first_d    = 1'b0;
            s_last_d     = 1'b0;
            s_dim_last_d = '0;
          end else begin
            s_first_d    = 1'b0;
            s_addr_d     = inc[0] ? origin_inc[0] : origin_ld;
            s_dim_last_d = nxt_dim_last;
            s_last_d     = nxt_dim_last[NDIM-1];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_addr_q     <= '0;
      s_first_q    <= 1'b0;
      s_last_q     <= 1'b0;
      s_dim_last_q <= '0;
      s_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_addr_q     <= s_addr_d;
      s_first_q    <= s_first_d;
      s_last_q     <= s_last_d;
      s_dim_last_q <= s_dim_last_d;
      s_valid_q    <= s_valid_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN);
  assign s_addr      = s_addr_q;
  assign s_first     = s_first_q;
  assign s_last      = s_last_q;
  assign s_dim_last  = s_dim_last_q;
  assign s_valid     = s_valid_q;

endmodule

// File: tb/tb_dma_dimn.sv
// Directed bench for dma_dimn (AW=14, NDIM=2): sequences, stalls, wrap, reset, back-to-back starts, step sign.
module tb_dma_dimn;

  localparam int AW   = 14;
  localparam int NDIM = 2;
  localparam int SW   = 8;
  localparam int STW  = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [AW-1:0]       base;
  logic [NDIM*SW-1:0]  size;
  logic [NDIM*STW-1:0] step;
  logic                start_valid;
  logic                start_ready;
  logic [AW-1:0]       s_addr;
  logic                s_first;
  logic                s_last;
  logic [NDIM-1:0]     s_dim_last;
  logic                s_valid;
  logic                s_ready;
  logic                busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] rec [64];
  logic [13:0] t1_addr [12] = '{14'h100, 14'h101, 14'h102, 14'h110, 14'h111, 14'h112,
                                14'h120, 14'h121, 14'h122, 14'h130, 14'h131, 14'h132};

  dma_dimn #(.AW(AW), .NDIM(NDIM), .SW(SW), .STW(STW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .base        (base),
    .size        (size),
    .step        (step),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .s_addr      (s_addr),
    .s_first     (s_first),
    .s_last      (s_last),
    .s_dim_last  (s_dim_last),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [13:0] a, input logic f, input logic l,
                                     input logic [1:0] dl);
    return {14'd0, a, f, l, dl};
  endfunction

  // Issue a descriptor from a sample point; returns at the sample point of cycle T+1.
  task automatic start_desc(input string tag, input logic [13:0] b, input logic [15:0] sz,
                            input logic [15:0] st);
    chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    base        = b;
    size        = sz;
    step        = st;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // Accept nb beats into rec[]; toggle applies the 1,0,0,1 ready pattern and checks stall stability.
  task automatic collect(input string tag, input int nb, input bit toggle, output int cyc);
    int          got;
    bit          stall_prev;
    logic [31:0] saved;
    logic [3:0]  pat;
    pat        = 4'b1001;
    got        = 0;
    cyc        = 0;
    stall_prev = 1'b0;
    saved      = '0;
    while (got < nb && cyc < 200) begin
      s_ready = toggle ? pat[3 - (cyc % 4)] : 1'b1;
      if (stall_prev) chk({tag, "_stall_hold"}, pk(s_addr, s_first, s_last, s_dim_last), saved);
      stall_prev = 1'b0;
      if (s_valid && s_ready) begin
        rec[got] = pk(s_addr, s_first, s_last, s_dim_last);
        got++;
      end else if (s_valid) begin
        saved      = pk(s_addr, s_first, s_last, s_dim_last);
        stall_prev = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_ready = 1'b1;
    if (got < nb) chk({tag, "_timeout_beats"}, 32'(got), 32'(nb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [13:0] exp4 [4];
    rst_n       = 1'b0;
    base        = '0;
    size        = '0;
    step        = '0;
    start_valid = 1'b0;
    s_ready     = 1'b1;
    #8;
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_outs", pk(s_addr, s_first, s_last, s_dim_last), pk(14'h0, 1'b0, 1'b0, 2'b00));
    chk("rst_busy", 32'(busy), 32'd0);
    #14 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_start_ready", 32'(start_ready), 32'd1);

    // 2-D walk, full throughput
    start_desc("t1", 14'h100, {8'd3, 8'd2}, {8'h10, 8'h01});
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_start_ready_run", 32'(start_ready), 32'd0);
    collect("t1", 12, 1'b0, cyc);
    for (int b = 0; b < 12; b++)
      chk($sformatf("t1_beat%0d", b), rec[b],
          pk(t1_addr[b], b == 0, b == 11, {b == 11, (b % 3) == 2}));
    chk("t1_cycles", 32'(cyc), 32'd12);
    chk("t1_end_valid", 32'(s_valid), 32'd0);
    chk("t1_end_start_ready", 32'(start_ready), 32'd1);
    chk("t1_end_busy", 32'(busy), 32'd0);

    // Same walk with backpressure
    start_desc("t2", 14'h100, {8'd3, 8'd2}, {8'h10, 8'h01});
    collect("t2", 12, 1'b1, cyc);
    for (int b = 0; b < 12; b++)
      chk($sformatf("t2_beat%0d", b), rec[b],
          pk(t1_addr[b], b == 0, b == 11, {b == 11, (b % 3) == 2}));
    chk("t2_end_valid", 32'(s_valid), 32'd0);

    // Single-beat descriptor
    start_desc("t3", 14'h3FFF, 16'h0000, 16'h0101);
    chk("t3_beat", pk(s_addr, s_first, s_last, s_dim_last), pk(14'h3FFF, 1'b1, 1'b1, 2'b11));
    chk("t3_valid", 32'(s_valid), 32'd1);
    @(posedge clk); #1;
    chk("t3_end_valid", 32'(s_valid), 32'd0);
    chk("t3_end_start_ready", 32'(start_ready), 32'd1);

    // Address wrap past 2^AW
    start_desc("t4", 14'h3FFE, {8'd0, 8'd3}, {8'h00, 8'h01});
    collect("t4", 4, 1'b0, cyc);
    exp4 = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    for (int b = 0; b < 4; b++)
      chk($sformatf("t4_beat%0d", b), rec[b], pk(exp4[b], b == 0, b == 3, {b == 3, b == 3}));

    // Reset in the middle of a descriptor
    start_desc("t5", 14'h100, {8'd3, 8'd2}, {8'h10, 8'h01});
    collect("t5a", 4, 1'b0, cyc);
    chk("t5_beat3", rec[3], pk(14'h110, 1'b0, 1'b0, 2'b00));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(s_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_addr", 32'(s_addr), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_post_valid", 32'(s_valid), 32'd0);
    start_desc("t5", 14'h200, {8'd1, 8'd1}, {8'h20, 8'h04});
    collect("t5b", 4, 1'b0, cyc);
    exp4 = '{14'h200, 14'h204, 14'h220, 14'h224};
    for (int b = 0; b < 4; b++)
      chk($sformatf("t5_beat%0d", b), rec[b],
          pk(exp4[b], b == 0, b == 3, {b == 3, (b % 2) == 1}));

    // start_valid held through RUN is taken only after the bubble
    start_desc("t6", 14'h040, {8'd0, 8'd1}, {8'h00, 8'h01});
    start_valid = 1'b1;
    base        = 14'h080;
    size        = 16'h0000;
    chk("t6_beat0", pk(s_addr, s_first, s_last, s_dim_last), pk(14'h040, 1'b1, 1'b0, 2'b00));
    chk("t6_start_ready_run", 32'(start_ready), 32'd0);
    @(posedge clk); #1;
    chk("t6_beat1", pk(s_addr, s_first, s_last, s_dim_last), pk(14'h041, 1'b0, 1'b1, 2'b11));
    @(posedge clk); #1;
    chk("t6_bubble_valid", 32'(s_valid), 32'd0);
    chk("t6_bubble_start_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("t6_second", pk(s_addr, s_first, s_last, s_dim_last), pk(14'h080, 1'b1, 1'b1, 2'b11));
    chk("t6_second_valid", 32'(s_valid), 32'd1);
    @(posedge clk); #1;

    // Step sign handling
    start_desc("t7", 14'h010, {8'd0, 8'd3}, {8'h00, 8'hFF});
    collect("t7", 4, 1'b0, cyc);
`ifdef DMA_DIMN_SIGNED_STEP_EN
    exp4 = '{14'h010, 14'h00F, 14'h00E, 14'h00D};
`else
    exp4 = '{14'h010, 14'h10F, 14'h20E, 14'h30D};
`endif
    for (int b = 0; b < 4; b++)
      chk($sformatf("t7_beat%0d", b), rec[b], pk(exp4[b], b == 0, b == 3, {b == 3, b == 3}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
